// File: rtl/hpi_pkg.sv
// Shared types for the HPI device-side responder: register select, STATUS bit
// positions and the bus FSM states.
package hpi_pkg;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        MAILBOX = 2'd1,
        ADDRESS = 2'd2,
        STATUS  = 2'd3
    } hpi_reg_e;

    localparam int ST_MBX_IN  = 0;
    localparam int ST_MBX_OUT = 1;
    localparam int ST_OVF     = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } hpi_state_e;

endpackage

// File: rtl/hpi_if.sv
// HPI strobe/select/interrupt group. The 16-bit data bus stays a plain inout
// on the responder so tristate resolution happens on an ordinary net.
interface hpi_if;
    logic [1:0] OTG_ADDR;
    logic       OTG_RD_N;
    logic       OTG_WR_N;
    logic       OTG_CS_N;
    logic       OTG_INT;

    modport master (output OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, input OTG_INT);
    modport slave  (input OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, output OTG_INT);
endinterface

// File: rtl/hpi_resp_ram.sv
// Single-port word RAM, synchronous read (read-before-write), no reset.
module hpi_resp_ram #(
    parameter int AW = 10
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [2**AW];

    always_ff @(posedge Clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/hpi_responder.sv
// HPI device-side responder: synchronized strobes, a three-state bus FSM,
// DATA/MAILBOX/ADDRESS/STATUS registers over a word RAM, and device mailboxes.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int AW          = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset_N,
    hpi_if.slave        bus,
    inout  wire  [15:0] OTG_DATA,
    output logic [15:0] dev_mbx_out,
    output logic        dev_mbx_out_valid,
    input  logic        dev_mbx_out_ack,
    input  logic [15:0] dev_mbx_in,
    input  logic        dev_mbx_in_wr
);
    // Synchronizer lanes: {addr[1:0], cs_n, wr_n, rd_n}
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic       rd_s, wr_s, cs_s, rd_act, wr_act, rd_act_q, wr_act_q;
    logic [1:0] addr_s;

    hpi_state_e state, state_nxt;
    hpi_reg_e   reg_sel;
    logic       start_rd, start_wr, rd_done, wr_commit;
    logic [15:0] ptr, rd_latch, wr_data_q, mbx_in, reg_rdata, status, ram_rdata;
    logic        mbx_in_full, ovf, int_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= {bus.OTG_ADDR, bus.OTG_CS_N, bus.OTG_WR_N, bus.OTG_RD_N};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {addr_s, cs_s, wr_s, rd_s} = sync_q[SYNC_STAGES-1];
    assign rd_act = ~rd_s & ~cs_s;
    assign wr_act = ~wr_s & ~cs_s;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Both strobes active is a protocol error: abandon without side effects.
    always_comb begin
        state_nxt = state;
        start_rd  = 1'b0;
        start_wr  = 1'b0;
        rd_done   = 1'b0;
        wr_commit = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rd_act && wr_act) state_nxt = S_IDLE;
                else if (rd_act && !rd_act_q) begin
                    state_nxt = S_RD;
                    start_rd  = 1'b1;
                end else if (wr_act && !wr_act_q) begin
                    state_nxt = S_WR;
                    start_wr  = 1'b1;
                end
            end
            S_RD: begin
                if (rd_act && wr_act) state_nxt = S_IDLE;
                else if (!rd_act) begin
                    state_nxt = S_IDLE;
                    rd_done   = 1'b1;
                end
            end
            S_WR: begin
                if (rd_act && wr_act) state_nxt = S_IDLE;
                else if (!wr_act) begin
                    state_nxt = S_IDLE;
                    wr_commit = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        status            = '0;
        status[ST_MBX_IN]  = mbx_in_full;
        status[ST_MBX_OUT] = dev_mbx_out_valid;
        status[ST_OVF]     = ovf;
    end

    // The RAM address follows the pointer continuously, so its registered
    // output already holds RAM[ptr] when a read is recognised.
    always_comb begin
        unique case (hpi_reg_e'(addr_s))
            DATA:    reg_rdata = ram_rdata;
            MAILBOX: reg_rdata = mbx_in;
            ADDRESS: reg_rdata = ptr;
            STATUS:  reg_rdata = status;
            default: reg_rdata = '0;
        endcase
    end

    hpi_resp_ram #(.AW(AW)) u_ram (
        .Clk   (Clk),
        .we    (wr_commit && reg_sel == DATA),
        .addr  (ptr[AW:1]),
        .wdata (wr_data_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            rd_act_q          <= 1'b0;
            wr_act_q          <= 1'b0;
            reg_sel           <= DATA;
            rd_latch          <= '0;
            wr_data_q         <= '0;
            ptr               <= '0;
            mbx_in            <= '0;
            mbx_in_full       <= 1'b0;
            ovf               <= 1'b0;
            int_q             <= 1'b0;
            dev_mbx_out       <= '0;
            dev_mbx_out_valid <= 1'b0;
        end else begin
            rd_act_q <= rd_act;
            wr_act_q <= wr_act;
            int_q    <= mbx_in_full;
            if (wr_act) wr_data_q <= OTG_DATA;
            if (start_rd || start_wr) reg_sel <= hpi_reg_e'(addr_s);
            if (start_rd) rd_latch <= reg_rdata;

            if (wr_commit && reg_sel == ADDRESS) ptr <= wr_data_q;
            else if ((wr_commit || rd_done) && reg_sel == DATA) ptr <= ptr + 16'd2;

            // A committing host write beats a same-cycle device ack.
            if (wr_commit && reg_sel == MAILBOX) begin
                dev_mbx_out       <= wr_data_q;
                dev_mbx_out_valid <= 1'b1;
                if (dev_mbx_out_valid && !dev_mbx_out_ack) ovf <= 1'b1;
            end else if (dev_mbx_out_ack) begin
                dev_mbx_out_valid <= 1'b0;
            end
            if (rd_done && reg_sel == STATUS) ovf <= 1'b0;

            if (dev_mbx_in_wr) begin
                mbx_in      <= dev_mbx_in;
                mbx_in_full <= 1'b1;
            end else if (rd_done && reg_sel == MAILBOX) begin
                mbx_in_full <= 1'b0;
            end
        end
    end

    assign OTG_DATA    = (state == S_RD) ? rd_latch : 16'hzzzz;
    assign bus.OTG_INT = int_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: pin-level host transactions and
// device pulses checked against a register-level model of the HPI device.
module tb_hpi_responder;
    import hpi_pkg::*;

    localparam int AW = 10;
    localparam int SYNC_STAGES = 2;

    logic        Clk, Reset_N;
    wire  [15:0] otg_data;
    logic [15:0] tb_dout;
    logic        tb_oe;
    logic [15:0] dev_mbx_out, dev_mbx_in;
    logic        dev_mbx_out_valid, dev_mbx_out_ack, dev_mbx_in_wr;
    int          n_tests, n_fail;

    hpi_if bus ();
    assign otg_data = tb_oe ? tb_dout : 16'hzzzz;

    hpi_responder #(.AW(AW), .SYNC_STAGES(SYNC_STAGES)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .bus(bus), .OTG_DATA(otg_data),
        .dev_mbx_out(dev_mbx_out), .dev_mbx_out_valid(dev_mbx_out_valid),
        .dev_mbx_out_ack(dev_mbx_out_ack), .dev_mbx_in(dev_mbx_in),
        .dev_mbx_in_wr(dev_mbx_in_wr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Device model at register level
    logic [15:0] ram_m [2**AW];
    bit          known_m [2**AW];
    logic [15:0] ptr_m, mbx_in_m, out_m;
    bit          full_m, ovf_m, outv_m;

    task automatic m_reset();
        ptr_m = 0; mbx_in_m = 0; out_m = 0; full_m = 0; ovf_m = 0; outv_m = 0;
    endtask

    task automatic m_write(input hpi_reg_e r, input logic [15:0] d);
        int idx;
        idx = (int'(ptr_m) / 2) % (2**AW);
        case (r)
            DATA:    begin ram_m[idx] = d; known_m[idx] = 1; ptr_m = ptr_m + 16'd2; end
            MAILBOX: begin if (outv_m) ovf_m = 1; out_m = d; outv_m = 1; end
            ADDRESS: ptr_m = d;
            default: ;
        endcase
    endtask

    task automatic m_read(input hpi_reg_e r, output logic [15:0] v, output bit known);
        int idx;
        idx = (int'(ptr_m) / 2) % (2**AW);
        known = 1;
        case (r)
            DATA:    begin v = ram_m[idx]; known = known_m[idx]; ptr_m = ptr_m + 16'd2; end
            MAILBOX: begin v = mbx_in_m; full_m = 0; end
            ADDRESS: v = ptr_m;
            default: begin v = {13'b0, ovf_m, outv_m, full_m}; ovf_m = 0; end
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic host_write(input hpi_reg_e r, input logic [15:0] d);
        tick(1);
        bus.OTG_ADDR = r; tb_dout = d; tb_oe = 1;
        bus.OTG_CS_N = 0; bus.OTG_WR_N = 0;
        tick(SYNC_STAGES + 3);
        bus.OTG_CS_N = 1; bus.OTG_WR_N = 1;
        tick(4);
        tb_oe = 0;
        tick(2);
        m_write(r, d);
    endtask

    task automatic host_read(input hpi_reg_e r, output logic [15:0] got,
                             output logic [15:0] exp, output bit known);
        tick(1);
        bus.OTG_ADDR = r; tb_oe = 0;
        bus.OTG_CS_N = 0; bus.OTG_RD_N = 0;
        tick(SYNC_STAGES + 3);
        got = otg_data;
        bus.OTG_CS_N = 1; bus.OTG_RD_N = 1;
        tick(4);
        m_read(r, exp, known);
    endtask

    task automatic dev_post(input logic [15:0] d);
        dev_mbx_in = d; dev_mbx_in_wr = 1;
        tick(1);
        dev_mbx_in_wr = 0;
        mbx_in_m = d; full_m = 1;
    endtask

    task automatic test_reset();
        Reset_N = 0; tb_oe = 1; tb_dout = 16'h0000;
        #1;
        n_tests++; if (otg_data !== 16'h0000) begin n_fail++; $display("FAIL reset_hiz: bus %h want 0000", otg_data); end
        n_tests++; if (bus.OTG_INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", bus.OTG_INT); end
        n_tests++; if (dev_mbx_out !== 16'h0 || dev_mbx_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mbx: out %h valid %b want 0000/0", dev_mbx_out, dev_mbx_out_valid); end
        tick(3);
        Reset_N = 1; tb_oe = 0;
        m_reset();
        tick(2);
    endtask

    task automatic test_data_ptr();
        logic [15:0] got, exp; bit known;
        host_write(ADDRESS, 16'h0010);
        host_write(DATA, 16'hAAAA);
        host_write(DATA, 16'h5555);
        host_write(ADDRESS, 16'h0010);
        host_read(DATA, got, exp, known);
        n_tests++; if (got !== 16'hAAAA) begin n_fail++; $display("FAIL data_rd0: got %h want AAAA", got); end
        host_read(DATA, got, exp, known);
        n_tests++; if (got !== 16'h5555) begin n_fail++; $display("FAIL data_rd1: got %h want 5555", got); end
        host_read(ADDRESS, got, exp, known);
        n_tests++; if (got !== 16'h0014) begin n_fail++; $display("FAIL ptr_after: got %h want 0014", got); end
    endtask

    task automatic test_wrap();
        logic [15:0] got, exp; bit known;
        host_write(ADDRESS, 16'hFFFE);
        host_write(DATA, 16'h1234);
        host_read(ADDRESS, got, exp, known);
        n_tests++; if (got !== 16'h0000) begin n_fail++; $display("FAIL wrap_ptr: got %h want 0000", got); end
        // 0x07FE indexes the same last word as 0xFFFE
        host_write(ADDRESS, 16'h07FE);
        host_read(DATA, got, exp, known);
        n_tests++; if (got !== 16'h1234) begin n_fail++; $display("FAIL wrap_ram: got %h want 1234", got); end
    endtask

    task automatic test_random_data();
        logic [15:0] got, exp, a; bit known; int op;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    a = 16'($urandom & 32'hF800) | 16'h0100 | 16'($urandom_range(0, 15) << 1)
                        | 16'($urandom & 1);
                    host_write(ADDRESS, a);
                end
                1: host_write(DATA, 16'($urandom));
                2: begin
                    host_read(DATA, got, exp, known);
                    if (known) begin
                        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, got, exp); end
                    end
                end
                default: begin
                    host_read(ADDRESS, got, exp, known);
                    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rnd_ptr[%0d]: got %h want %h", i, got, exp); end
                end
            endcase
        end
    endtask

    task automatic test_h2d_mailbox();
        logic [15:0] got, exp; bit known;
        host_write(MAILBOX, 16'hBEEF);
        n_tests++; if (dev_mbx_out !== out_m || dev_mbx_out_valid !== outv_m) begin
            n_fail++; $display("FAIL h2d_out: %h/%b want %h/%b", dev_mbx_out, dev_mbx_out_valid, out_m, outv_m); end
        host_read(STATUS, got, exp, known);
        n_tests++; if (got !== exp || got !== 16'h0002) begin n_fail++; $display("FAIL h2d_st0: got %h want %h", got, exp); end
        host_write(MAILBOX, 16'hCAFE);
        host_read(STATUS, got, exp, known);
        n_tests++; if (got !== exp || got !== 16'h0006) begin n_fail++; $display("FAIL h2d_ovf: got %h want %h", got, exp); end
        host_read(STATUS, got, exp, known);
        n_tests++; if (got !== exp || got !== 16'h0002) begin n_fail++; $display("FAIL h2d_ovfclr: got %h want %h", got, exp); end
        dev_mbx_out_ack = 1; tick(1); dev_mbx_out_ack = 0; outv_m = 0;
        n_tests++; if (dev_mbx_out_valid !== outv_m) begin n_fail++; $display("FAIL h2d_ack: valid %b want 0", dev_mbx_out_valid); end
        // Host write commits on the same cycle as a device ack: write wins, no overflow
        host_write(MAILBOX, 16'h1111);
        tick(1);
        bus.OTG_ADDR = MAILBOX; tb_dout = 16'h2222; tb_oe = 1;
        bus.OTG_CS_N = 0; bus.OTG_WR_N = 0;
        tick(SYNC_STAGES + 3);
        bus.OTG_CS_N = 1; bus.OTG_WR_N = 1;
        tick(SYNC_STAGES);
        dev_mbx_out_ack = 1;
        tick(1);
        dev_mbx_out_ack = 0;
        tick(2);
        tb_oe = 0;
        out_m = 16'h2222; outv_m = 1;
        n_tests++; if (dev_mbx_out !== out_m || dev_mbx_out_valid !== outv_m) begin
            n_fail++; $display("FAIL h2d_ack_race: %h/%b want %h/%b", dev_mbx_out, dev_mbx_out_valid, out_m, outv_m); end
        host_read(STATUS, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL h2d_race_st: got %h want %h", got, exp); end
    endtask

    task automatic test_d2h_mailbox();
        logic [15:0] got, exp; bit known;
        dev_post(16'h00C3);
        tick(1);
        n_tests++; if (bus.OTG_INT !== 1'b1) begin n_fail++; $display("FAIL d2h_int_set: got %b want 1", bus.OTG_INT); end
        host_read(MAILBOX, got, exp, known);
        n_tests++; if (got !== 16'h00C3) begin n_fail++; $display("FAIL d2h_rd: got %h want 00C3", got); end
        n_tests++; if (bus.OTG_INT !== full_m) begin n_fail++; $display("FAIL d2h_int_clr: got %b want %b", bus.OTG_INT, full_m); end
        // Device post lands on the cycle the host MAILBOX read completes
        dev_post(16'h0011);
        tick(2);
        bus.OTG_ADDR = MAILBOX; bus.OTG_CS_N = 0; bus.OTG_RD_N = 0;
        tick(SYNC_STAGES + 3);
        got = otg_data;
        bus.OTG_CS_N = 1; bus.OTG_RD_N = 1;
        tick(SYNC_STAGES);
        m_read(MAILBOX, exp, known);
        dev_post(16'h0022);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL d2h_race_rd: got %h want %h", got, exp); end
        tick(3);
        n_tests++; if (bus.OTG_INT !== 1'b1) begin n_fail++; $display("FAIL d2h_race_int: got %b want 1", bus.OTG_INT); end
        host_read(MAILBOX, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL d2h_rd2: got %h want %h", got, exp); end
    endtask

    task automatic test_bus_discipline();
        logic [15:0] got, exp; bit known;
        host_write(ADDRESS, 16'h0200);
        host_write(DATA, 16'hA5A5);
        host_write(ADDRESS, 16'h0200);
        host_read(DATA, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bus_prep: got %h want %h", got, exp); end
        tb_dout = 16'h0000; tb_oe = 1;
        tick(2);
        n_tests++; if (otg_data !== 16'h0000) begin n_fail++; $display("FAIL bus_cs_hi: bus %h want 0000", otg_data); end
        bus.OTG_ADDR = DATA; bus.OTG_RD_N = 0;
        tick(SYNC_STAGES + 4);
        n_tests++; if (otg_data !== 16'h0000) begin n_fail++; $display("FAIL bus_rd_nocs: bus %h want 0000", otg_data); end
        bus.OTG_RD_N = 1;
        tick(3);
        // DATA write of zero while the read latch still holds A5A5
        bus.OTG_CS_N = 0; bus.OTG_WR_N = 0;
        tick(SYNC_STAGES + 3);
        n_tests++; if (otg_data !== 16'h0000) begin n_fail++; $display("FAIL bus_wr: bus %h want 0000", otg_data); end
        bus.OTG_CS_N = 1; bus.OTG_WR_N = 1;
        tick(4);
        m_write(DATA, 16'h0000);
        host_write(ADDRESS, 16'h0202);
        tb_dout = 16'h0F0F; tb_oe = 1;
        bus.OTG_ADDR = DATA; bus.OTG_CS_N = 0; bus.OTG_RD_N = 0; bus.OTG_WR_N = 0;
        tick(SYNC_STAGES + 4);
        n_tests++; if (otg_data !== 16'h0F0F) begin n_fail++; $display("FAIL bus_both: bus %h want 0F0F", otg_data); end
        bus.OTG_CS_N = 1; bus.OTG_RD_N = 1; bus.OTG_WR_N = 1;
        tick(4);
        tb_oe = 0;
        host_read(DATA, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bus_both_ram: got %h want %h", got, exp); end
        host_read(ADDRESS, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bus_both_ptr: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] got, exp; bit known;
        dev_post(16'h0055);
        host_write(ADDRESS, 16'h0200);
        tick(1);
        bus.OTG_ADDR = DATA; bus.OTG_CS_N = 0; bus.OTG_RD_N = 0;
        tick(SYNC_STAGES + 3);
        n_tests++; if (otg_data !== 16'hA5A5) begin n_fail++; $display("FAIL rst_pre: bus %h want A5A5", otg_data); end
        Reset_N = 0; tb_dout = 16'h0000; tb_oe = 1;
        #1;
        n_tests++; if (otg_data !== 16'h0000) begin n_fail++; $display("FAIL rst_hiz: bus %h want 0000", otg_data); end
        n_tests++; if (bus.OTG_INT !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b want 0", bus.OTG_INT); end
        tick(1);
        bus.OTG_CS_N = 1; bus.OTG_RD_N = 1;
        tick(3);
        Reset_N = 1; tb_oe = 0;
        m_reset();
        tick(2);
        host_read(STATUS, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rst_status: got %h want %h", got, exp); end
        host_read(ADDRESS, got, exp, known);
        n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rst_ptr: got %h want %h", got, exp); end
        host_write(ADDRESS, 16'h0200);
        host_read(DATA, got, exp, known);
        n_tests++; if (got !== 16'hA5A5) begin n_fail++; $display("FAIL rst_ram_kept: got %h want A5A5", got); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        bus.OTG_ADDR = 2'b00; bus.OTG_CS_N = 1; bus.OTG_RD_N = 1; bus.OTG_WR_N = 1;
        tb_dout = 0; tb_oe = 0;
        dev_mbx_in = 0; dev_mbx_in_wr = 0; dev_mbx_out_ack = 0;
        foreach (known_m[i]) known_m[i] = 0;
        m_reset();
        test_reset();
        test_data_ptr();
        test_wrap();
        test_random_data();
        test_h2d_mailbox();
        test_d2h_mailbox();
        test_bus_discipline();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
